// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the product accumulator.
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam int PROD_W    = 16;
  localparam int DEF_LEN   = 8;
  localparam int DEF_ACC_W = 20;

endpackage

// File: rtl/prod_accum_sat_add.sv
// Signed saturating adder: one guard bit, clamps to the W-bit signed range.
module sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};

  // Guard bit and MSB disagree exactly when the true sum leaves the W-bit range.
  always_comb begin
    ovf = wide[W] ^ wide[W-1];
    if (!ovf) begin
      sum = wide[W-1:0];
    end else if (wide[W]) begin
      sum = {1'b1, {(W-1){1'b0}}};
    end else begin
      sum = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator: sums LEN signed products with saturation, then holds
// the registered result until the downstream handshake.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_valid,
  input  logic signed [PROD_W-1:0] i_prod,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf,
  input  logic                    i_ready
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  add_sum;
  logic                     add_ovf;
  logic                     ovf;
  logic                     take;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_inc;

  assign prod_ext = ACC_W'(i_prod);
  assign take     = i_valid && o_ready;
  assign cnt_inc  = cnt + 1'b1;

  sat_add #(
    .W(ACC_W)
  ) u_sat_add (
    .a  (acc),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // acc is zero in IDLE, so the first product also goes through the adder.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      o_sum   <= '0;
      o_ovf   <= 1'b0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            acc   <= add_sum;
            ovf   <= add_ovf;
            cnt   <= CNT_W'(1);
            state <= ACC;
          end
        end
        ACC: begin
          if (take) begin
            acc <= add_sum;
            ovf <= ovf | add_ovf;
            cnt <= cnt_inc;
            if (cnt_inc == LAST) begin
              state   <= DONE;
              o_sum   <= add_sum;
              o_ovf   <= ovf | add_ovf;
              o_valid <= 1'b1;
              o_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          acc     <= '0;
          cnt     <= '0;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: three parameterisations, directed and random frames.
module tb_prod_accum;

  logic        i_clk;
  logic        rst_n;
  logic        clr;
  logic        valid;
  logic        ready;
  logic signed [15:0] prod;
  int          sel;

  logic va, vb, vc;
  logic rdy_a, rdy_b, rdy_c;
  logic ov_a, ov_b, ov_c;
  logic ovf_a, ovf_b, ovf_c;
  logic signed [19:0] sum_a;
  logic signed [15:0] sum_b, sum_c;

  logic               o_ready_m, o_valid_m, o_ovf_m;
  logic signed [31:0] o_sum_m;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_frame[$];
  bit m_pending;
  int m_sum;
  bit m_ovf;

  assign va = valid && (sel == 0);
  assign vb = valid && (sel == 1);
  assign vc = valid && (sel == 2);

  prod_accum #(.LEN(4), .ACC_W(20)) u_a (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_clr(clr), .i_valid(va), .i_prod(prod),
    .o_ready(rdy_a), .o_valid(ov_a), .o_sum(sum_a), .o_ovf(ovf_a), .i_ready(ready)
  );
  prod_accum #(.LEN(4), .ACC_W(16)) u_b (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_clr(clr), .i_valid(vb), .i_prod(prod),
    .o_ready(rdy_b), .o_valid(ov_b), .o_sum(sum_b), .o_ovf(ovf_b), .i_ready(ready)
  );
  prod_accum #(.LEN(2), .ACC_W(16)) u_c (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_clr(clr), .i_valid(vc), .i_prod(prod),
    .o_ready(rdy_c), .o_valid(ov_c), .o_sum(sum_c), .o_ovf(ovf_c), .i_ready(ready)
  );

  always_comb begin
    o_ready_m = rdy_a;
    o_valid_m = ov_a;
    o_ovf_m   = ovf_a;
    o_sum_m   = {{12{sum_a[19]}}, sum_a};
    if (sel == 1) begin
      o_ready_m = rdy_b;
      o_valid_m = ov_b;
      o_ovf_m   = ovf_b;
      o_sum_m   = {{16{sum_b[15]}}, sum_b};
    end else if (sel == 2) begin
      o_ready_m = rdy_c;
      o_valid_m = ov_c;
      o_ovf_m   = ovf_c;
      o_sum_m   = {{16{sum_c[15]}}, sum_c};
    end
  end

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int cur_len();
    return (sel == 2) ? 2 : 4;
  endfunction

  function automatic int cur_w();
    return (sel == 0) ? 20 : 16;
  endfunction

  // Running sum clamped to the signed cur_w()-bit range after every product.
  task automatic sat_frame(input int q[$], output int s, output bit o);
    longint mx, mn, acc;
    mx  = (longint'(1) << (cur_w() - 1)) - 1;
    mn  = -mx - 1;
    acc = 0;
    o   = 1'b0;
    foreach (q[i]) begin
      acc = acc + q[i];
      if (acc > mx) begin acc = mx; o = 1'b1; end
      if (acc < mn) begin acc = mn; o = 1'b1; end
    end
    s = int'(acc);
  endtask

  task automatic model_edge();
    if (!rst_n || clr) begin
      m_pending = 1'b0;
      m_frame.delete();
      m_sum = 0;
      m_ovf = 1'b0;
    end else if (m_pending) begin
      if (ready) begin
        m_pending = 1'b0;
        m_frame.delete();
      end
    end else if (valid) begin
      m_frame.push_back(int'(prod));
      if (m_frame.size() == cur_len()) begin
        sat_frame(m_frame, m_sum, m_ovf);
        m_pending = 1'b1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 32385;
    if (r == 1) return -32640;
    return int'($urandom_range(0, 65025)) - 32640;
  endfunction

  task automatic test_reset();
    sel = 0;
    ready = 1'b0;
    do_reset();
    checks++; if (o_valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_valid_m); end
    checks++; if (o_ready_m !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", o_ready_m); end
    checks++; if (o_sum_m !== 32'sd0) begin errors++; $display("FAIL reset_sum got %0d want 0", o_sum_m); end
    checks++; if (o_ovf_m !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", o_ovf_m); end
  endtask

  task automatic test_basic();
    int p[4] = '{100, -50, 32385, -32640};
    sel = 0;
    do_reset();
    ready = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod = 16'(p[i]);
      step();
      if (i < 3) begin
        checks++; if (o_valid_m !== 1'b0) begin errors++; $display("FAIL basic_early_valid idx %0d got %0b want 0", i, o_valid_m); end
      end
    end
    valid = 1'b0;
    checks++; if (o_valid_m !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", o_valid_m); end
    checks++; if (o_sum_m !== -32'sd205) begin errors++; $display("FAIL basic_sum got %0d want -205", o_sum_m); end
    checks++; if (o_ovf_m !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b want 0", o_ovf_m); end
    checks++; if (o_ready_m !== 1'b0) begin errors++; $display("FAIL basic_done_ready got %0b want 0", o_ready_m); end
    step();
    checks++; if (o_valid_m !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %0b want 0", o_valid_m); end
    checks++; if (o_ready_m !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got %0b want 1", o_ready_m); end
  endtask

  task automatic test_saturation();
    // positive clamp: ACC_W=16, LEN=4
    sel = 1;
    do_reset();
    ready = 1'b0;
    valid = 1'b1;
    prod  = 16'sd32385;
    for (int i = 0; i < 4; i++) step();
    valid = 1'b0;
    checks++; if (o_valid_m !== 1'b1) begin errors++; $display("FAIL satpos_valid got %0b want 1", o_valid_m); end
    checks++; if (o_sum_m !== 32'sd32767) begin errors++; $display("FAIL satpos_sum got %0d want 32767", o_sum_m); end
    checks++; if (o_ovf_m !== 1'b1) begin errors++; $display("FAIL satpos_ovf got %0b want 1", o_ovf_m); end
    // negative clamp: ACC_W=16, LEN=2
    sel = 2;
    do_reset();
    valid = 1'b1;
    prod  = -16'sd32640;
    for (int i = 0; i < 2; i++) step();
    valid = 1'b0;
    checks++; if (o_valid_m !== 1'b1) begin errors++; $display("FAIL satneg_valid got %0b want 1", o_valid_m); end
    checks++; if (o_sum_m !== -32'sd32768) begin errors++; $display("FAIL satneg_sum got %0d want -32768", o_sum_m); end
    checks++; if (o_ovf_m !== 1'b1) begin errors++; $display("FAIL satneg_ovf got %0b want 1", o_ovf_m); end
  endtask

  task automatic test_back_to_back();
    int exp_sum;
    sel = 0;
    do_reset();
    ready   = 1'b0;
    valid   = 1'b1;
    exp_sum = 0;
    for (int i = 0; i < 4; i++) begin
      int v;
      v = pick();
      exp_sum += v;
      prod = 16'(v);
      step();
    end
    prod = 16'sd30000;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (o_sum_m !== exp_sum) begin errors++; $display("FAIL stall_sum cyc %0d got %0d want %0d", i, o_sum_m, exp_sum); end
      checks++; if (o_ready_m !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %0b want 0", i, o_ready_m); end
      checks++; if (o_valid_m !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %0b want 1", i, o_valid_m); end
    end
    ready = 1'b1;
    step();
    checks++; if (o_valid_m !== 1'b0) begin errors++; $display("FAIL handoff_valid got %0b want 0", o_valid_m); end
    checks++; if (o_ready_m !== 1'b1) begin errors++; $display("FAIL handoff_ready got %0b want 1", o_ready_m); end
    for (int i = 1; i <= 4; i++) begin
      prod = 16'(i);
      step();
    end
    valid = 1'b0;
    checks++; if (o_valid_m !== 1'b1) begin errors++; $display("FAIL bubble_valid got %0b want 1", o_valid_m); end
    checks++; if (o_sum_m !== 32'sd10) begin errors++; $display("FAIL bubble_sum got %0d want 10", o_sum_m); end
    step();
  endtask

  task automatic test_clear();
    sel = 0;
    do_reset();
    ready = 1'b1;
    valid = 1'b1;
    prod  = 16'sd500; step();
    prod  = 16'sd600; step();
    clr   = 1'b1;
    prod  = 16'sd7000;
    step();
    clr   = 1'b0;
    checks++; if (o_valid_m !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b want 0", o_valid_m); end
    checks++; if (o_ovf_m !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", o_ovf_m); end
    for (int i = 1; i <= 4; i++) begin
      prod = 16'(i);
      step();
    end
    valid = 1'b0;
    checks++; if (o_valid_m !== 1'b1) begin errors++; $display("FAIL clr_frame_valid got %0b want 1", o_valid_m); end
    checks++; if (o_sum_m !== 32'sd10) begin errors++; $display("FAIL clr_frame_sum got %0d want 10", o_sum_m); end
    step();
  endtask

  task automatic test_reset_in_done();
    sel = 0;
    do_reset();
    ready = 1'b0;
    valid = 1'b1;
    prod  = 16'sd1234;
    for (int i = 0; i < 4; i++) step();
    valid = 1'b0;
    checks++; if (o_valid_m !== 1'b1) begin errors++; $display("FAIL rstdone_pre_valid got %0b want 1", o_valid_m); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (o_valid_m !== 1'b0) begin errors++; $display("FAIL rstdone_valid got %0b want 0", o_valid_m); end
    checks++; if (o_sum_m !== 32'sd0) begin errors++; $display("FAIL rstdone_sum got %0d want 0", o_sum_m); end
    checks++; if (o_ready_m !== 1'b1) begin errors++; $display("FAIL rstdone_ready got %0b want 1", o_ready_m); end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (o_valid_m !== 1'b0) begin errors++; $display("FAIL rstdone_lost cyc %0d got %0b want 0", i, o_valid_m); end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      for (int c = 0; c < 400; c++) begin
        valid = ($urandom_range(0, 9) < 7);
        ready = ($urandom_range(0, 9) < 6);
        clr   = ($urandom_range(0, 99) < 2);
        prod  = 16'(pick());
        step();
        checks++; if (o_valid_m !== m_pending) begin errors++; $display("FAIL rnd_valid sel %0d cyc %0d got %0b want %0b", s, c, o_valid_m, m_pending); end
        checks++; if (o_ready_m !== !m_pending) begin errors++; $display("FAIL rnd_ready sel %0d cyc %0d got %0b want %0b", s, c, o_ready_m, !m_pending); end
        if (m_pending) begin
          checks++; if (o_sum_m !== m_sum) begin errors++; $display("FAIL rnd_sum sel %0d cyc %0d got %0d want %0d", s, c, o_sum_m, m_sum); end
          checks++; if (o_ovf_m !== m_ovf) begin errors++; $display("FAIL rnd_ovf sel %0d cyc %0d got %0b want %0b", s, c, o_ovf_m, m_ovf); end
        end
      end
      clr = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    prod  = '0;
    sel   = 0;
    m_pending = 1'b0;
    m_sum = 0;
    m_ovf = 1'b0;
    @(posedge i_clk);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_reset_in_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The block SHALL have parameter LEN, default 8, meaning the number of products summed per frame (legal range 2..256).
REQ-002 The block SHALL have parameter ACC_W, default 20, meaning the accumulator and result width in bits (legal range 16..32).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_clr, input, 1 bit: synchronous frame flush.
REQ-006 The block SHALL have port i_valid, input, 1 bit: i_prod is valid this cycle.
REQ-007 The block SHALL have port i_prod, input, 16 bits signed: product from the upstream signed-by-unsigned 8x8 multiplier, range -32640..32385.
REQ-008 The block SHALL have port o_ready, output, 1 bit: the block accepts i_prod this cycle.
REQ-009 The block SHALL have port o_valid, output, 1 bit: o_sum and o_ovf hold a completed frame.
REQ-010 The block SHALL have port o_sum, output, ACC_W bits signed: saturated frame sum.
REQ-011 The block SHALL have port o_ovf, output, 1 bit: saturation occurred at least once in the frame.
REQ-012 The block SHALL have port i_ready, input, 1 bit: downstream consumes the result when o_valid and i_ready are both high.

Function
REQ-013 A product SHALL be accepted only in a cycle where i_valid and o_ready are both high.
REQ-014 The state machine SHALL have three states: IDLE (acc=0, cnt=0, o_ready=1), ACC (o_ready=1), and DONE (o_ready=0, o_valid=1).
REQ-015 IDLE SHALL go to ACC on an accepted product: acc becomes sext(i_prod), cnt becomes 1, and ovf is cleared.
REQ-016 ACC SHALL, on each accepted product, set acc to sat(acc + sext(i_prod)) and increment cnt; with no accepted product it SHALL hold.
REQ-017 When the accepted product makes cnt equal LEN, the next state SHALL be DONE, with o_sum = final acc and o_valid = 1 in the following cycle (one-cycle latency from the last product).
REQ-018 Saturation SHALL clamp positive overflow to 2^(ACC_W-1)-1 and negative overflow to -2^(ACC_W-1), and SHALL set a sticky ovf flag for the frame.
REQ-019 Sign extension and addition SHALL use ACC_W+1 bits; overflow SHALL be detected when the top two bits of the (ACC_W+1)-bit sum differ.
REQ-020 DONE SHALL hold o_sum, o_ovf and o_valid stable until i_ready is high, then go to IDLE; the block SHALL accept no product in the DONE state or in the handoff cycle (one-cycle bubble).
REQ-021 i_valid asserted while o_ready is low SHALL be ignored, with no state change.
REQ-022 i_clr high SHALL force IDLE, acc=0, cnt=0, o_valid=0 and o_ovf=0 on the next edge, override every other input, and discard any unconsumed result.
REQ-023 cnt SHALL be $clog2(LEN+1) bits wide and SHALL never wrap.

Reset
REQ-024 When i_rst_n is low at a rising edge, the block SHALL go to state IDLE with acc=0, cnt=0, o_sum=0, o_valid=0, o_ovf=0 and o_ready=1 in the next cycle.
REQ-025 Reset SHALL take priority over i_clr, and reset mid-frame or in DONE SHALL discard the partial or held result.

Structure
REQ-026 A shared package prod_accum_pkg SHALL hold the state enum (IDLE, ACC, DONE), the product width constant PROD_W=16, and the default LEN and ACC_W.
REQ-027 Saturating addition SHALL be a sub-module sat_add, parameterised by width, that outputs the clamped sum and an overflow bit.
REQ-028 The block SHALL contain no combinational path from i_valid or i_prod to o_sum or o_valid.

Verification
REQ-029 With LEN=4, ACC_W=20 and products 100, -50, 32385, -32640 on consecutive cycles with i_ready=1, the bench SHALL see o_valid one cycle after the 4th product, o_sum=-205, o_ovf=0, then IDLE.
REQ-030 With ACC_W=16, LEN=4 and four products of 32385, the bench SHALL see o_sum=32767 and o_ovf=1.
REQ-031 With ACC_W=16, LEN=2 and products -32640, -32640, the bench SHALL see o_sum=-32768 and o_ovf=1.
REQ-032 With i_ready held low for 5 cycles after o_valid and i_valid=1 throughout, the bench SHALL see o_sum stable, o_ready=0, no product absorbed, and the next frame starting only after the bubble cycle.
REQ-033 With i_clr pulsed after 2 of 4 products, followed by products 1, 2, 3, 4, the bench SHALL see o_sum=10 with no contribution from the flushed products.
REQ-034 With i_rst_n low for 1 cycle while in DONE, the bench SHALL see o_valid=0, o_sum=0, o_ready=1 on the next cycle and the held result lost.
